// File: rtl/regfile_param_if.sv
// ---------------------------------------------------------------------------
// regfile_param_if
// Bus bundle between the pipeline (decode read addresses, writeback write
// port) and the register file.
//
//   clear    master->slave  single-cycle request to re-zero the array
//   ready    slave->master  clear engine idle, file usable
//   wr_en    master->slave  write enable
//   wr_addr  master->slave  write address (ADDR_W)
//   wr_data  master->slave  write data (DATA_W)
//   rd_en    master->slave  per-port read enable (NRD), 0 holds the port
//   rd_addr  master->slave  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  slave->master  packed registered read data, port i at [i*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic                   clear;
  logic                   ready;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic [NRD-1:0]         rd_en;
  logic [NRD*ADDR_W-1:0]  rd_addr;
  logic [NRD*DATA_W-1:0]  rd_data;

  modport master (
    output clear, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  ready, rd_data
  );

  modport slave (
    input  clear, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output ready, rd_data
  );
endinterface

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
// Parametrised integer register file: one write port, NRD registered read
// ports with per-port hold, entry 0 hardwired to zero. A sequential clear
// engine zeroes entries 1..DEPTH-1 after reset or on a clear request, so the
// storage array itself carries no reset.
//
// Ports:
//   clk      core clock, all state on the rising edge
//   reset_n  asynchronous active-low reset (restarts the clear sequence)
//   bus      regfile_param_if.slave: clear/ready, write port, read ports
//
// Parameters: DATA_W (register width), ADDR_W (DEPTH = 2**ADDR_W),
//             NRD (read ports, 1..4)
//
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle write
// to a read of the same address. Without it such a read returns the old
// contents.
// ---------------------------------------------------------------------------
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  regfile_param_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic                ready_q, ready_d;

  // Storage; entry 0 is never written and always masked on read.
  logic [DATA_W-1:0]   mem [DEPTH];

  // Single shared write port, owned by the clear engine while clearing.
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // -------------------------------------------------------------------------
  // Clear engine / write arbitration
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;

    case (state_q)
      ST_CLEAR: begin
        // Pipeline writes are ignored; the engine owns the port.
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        if (bus.clear) begin
          clr_idx_d = FIRST_IDX;
        end else if (clr_idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + FIRST_IDX;
        end
      end

      ST_IDLE: begin
        if (bus.clear) begin
          // A write coinciding with the clear request is dropped.
          state_d   = ST_CLEAR;
          clr_idx_d = FIRST_IDX;
          ready_d   = 1'b0;
        end else if (bus.wr_en && (bus.wr_addr != '0)) begin
          mem_we = 1'b1;
        end
      end

      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = FIRST_IDX;
        ready_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= FIRST_IDX;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.ready = ready_q;

  // -------------------------------------------------------------------------
  // Registered read ports
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data_q, data_d;

      assign addr = bus.rd_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        data_d = data_q;
        if (state_q == ST_CLEAR) begin
          data_d = '0;
        end else if (bus.rd_en[gi]) begin
          if (addr == '0) begin
            data_d = '0;
`ifdef REGFILE_BYPASS_EN
          // In IDLE mem_we is only set for an accepted pipeline write,
          // so mem_waddr equals wr_addr here.
          end else if (mem_we && (mem_waddr == addr)) begin
            data_d = bus.wr_data;
`endif
          end else begin
            data_d = mem[addr];
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          data_q <= '0;
        end else begin
          data_q <= data_d;
        end
      end

      assign bus.rd_data[gi*DATA_W +: DATA_W] = data_q;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_param
// Directed bench: instance A uses the default parameters (32x32, 2 read
// ports); instance B uses ADDR_W=3, NRD=3.
// ---------------------------------------------------------------------------
module tb_regfile_param;

  logic clk;
  logic rst_n_a;
  logic rst_n_b;

  int n_vec = 0;
  int n_err = 0;

  regfile_param_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus_a ();
  regfile_param_if #(.DATA_W(32), .ADDR_W(3), .NRD(3)) bus_b ();

  regfile_param #(.DATA_W(32), .ADDR_W(5), .NRD(2)) u_dut_a (
    .clk     (clk),
    .reset_n (rst_n_a),
    .bus     (bus_a)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(3), .NRD(3)) u_dut_b (
    .clk     (clk),
    .reset_n (rst_n_b),
    .bus     (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic count_ready_a(output int cnt);
    cnt = 0;
    while (!bus_a.ready && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic count_ready_b(output int cnt);
    cnt = 0;
    while (!bus_b.ready && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  logic [31:0] exp_v;
  int          cnt;

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    bus_a.clear = 1'b0; bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_a.rd_en = '0;   bus_a.rd_addr = '0;
    bus_b.clear = 1'b0; bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    bus_b.rd_en = '0;   bus_b.rd_addr = '0;

    tick();
    tick();
    check("a_rst_ready", 32'(bus_a.ready), 32'd0);
    check("a_rst_rd0", bus_a.rd_data[31:0], 32'd0);
    check("a_rst_rd1", bus_a.rd_data[63:32], 32'd0);

    // ---- A: clear after reset release takes 31 edges
    rst_n_a = 1'b1;
    count_ready_a(cnt);
    check("a_clear_len", 32'(cnt), 32'd31);

    for (int a = 1; a < 32; a++) begin
      bus_a.rd_en = 2'b11;
      bus_a.rd_addr = {5'(32 - a), 5'(a)};
      tick();
      check($sformatf("a_init_p0_x%0d", a), bus_a.rd_data[31:0], 32'd0);
      check($sformatf("a_init_p1_x%0d", 32 - a), bus_a.rd_data[63:32], 32'd0);
    end

    // ---- write x5, read x5 / x0
    bus_a.rd_en = 2'b00;
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd5; bus_a.wr_data = 32'hDEADBEEF;
    tick();
    bus_a.wr_en = 1'b0;
    bus_a.rd_en = 2'b11; bus_a.rd_addr = {5'd0, 5'd5};
    tick();
    check("a_rd_x5", bus_a.rd_data[31:0], 32'hDEADBEEF);
    check("a_rd_x0", bus_a.rd_data[63:32], 32'd0);

    // ---- write to x0 is discarded
    bus_a.rd_en = 2'b00;
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd0; bus_a.wr_data = 32'h1234;
    tick();
    bus_a.wr_en = 1'b0;
    bus_a.rd_en = 2'b01; bus_a.rd_addr = {5'd0, 5'd0};
    tick();
    check("a_x0_after_wr", bus_a.rd_data[31:0], 32'd0);

    // ---- same-cycle write/read of x7
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd7; bus_a.wr_data = 32'hA5A5A5A5;
    bus_a.rd_en = 2'b01; bus_a.rd_addr = {5'd0, 5'd7};
    tick();
`ifdef REGFILE_BYPASS_EN
    exp_v = 32'hA5A5A5A5;
`else
    exp_v = 32'd0;
`endif
    check("a_x7_same_cycle", bus_a.rd_data[31:0], exp_v);
    bus_a.wr_en = 1'b0;
    tick();
    check("a_x7_next_cycle", bus_a.rd_data[31:0], 32'hA5A5A5A5);

    // ---- read hold
    bus_a.rd_en = 2'b00;
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd4; bus_a.wr_data = 32'h44;
    tick();
    bus_a.wr_addr = 5'd3; bus_a.wr_data = 32'h11;
    tick();
    bus_a.wr_en = 1'b0;
    bus_a.rd_en = 2'b01; bus_a.rd_addr = {5'd0, 5'd3};
    tick();
    check("a_rd_x3", bus_a.rd_data[31:0], 32'h11);
    bus_a.rd_en = 2'b00; bus_a.rd_addr = {5'd0, 5'd4};
    tick();
    check("a_hold_p0", bus_a.rd_data[31:0], 32'h11);
    bus_a.rd_en = 2'b01;
    tick();
    check("a_rd_x4", bus_a.rd_data[31:0], 32'h44);

    // ---- fill with index, then clear with concurrent write
    bus_a.rd_en = 2'b00;
    for (int a = 1; a < 32; a++) begin
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'(a); bus_a.wr_data = 32'(a);
      tick();
    end
    bus_a.wr_en = 1'b0;
    bus_a.rd_en = 2'b11; bus_a.rd_addr = {5'd31, 5'd2};
    tick();
    check("a_fill_x2", bus_a.rd_data[31:0], 32'd2);
    check("a_fill_x31", bus_a.rd_data[63:32], 32'd31);

    bus_a.clear = 1'b1;
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd2; bus_a.wr_data = 32'h99;
    bus_a.rd_addr = {5'd31, 5'd2};
    tick();
    bus_a.clear = 1'b0;
    bus_a.wr_en = 1'b0;
    check("a_clr_req_ready", 32'(bus_a.ready), 32'd0);
    cnt = 0;
    while (!bus_a.ready && cnt < 100) begin
      tick();
      cnt++;
      if (cnt == 5) begin
        check("a_clr_mid_rd0", bus_a.rd_data[31:0], 32'd0);
        check("a_clr_mid_rd1", bus_a.rd_data[63:32], 32'd0);
      end
    end
    check("a_clear2_len", 32'(cnt), 32'd31);
    for (int a = 1; a < 32; a++) begin
      bus_a.rd_addr = {5'(a), 5'(a)};
      tick();
      check($sformatf("a_post_clr_x%0d", a), bus_a.rd_data[31:0], 32'd0);
    end

    // ---- B: ADDR_W=3, NRD=3
    check("b_rst_ready", 32'(bus_b.ready), 32'd0);
    rst_n_b = 1'b1;
    count_ready_b(cnt);
    check("b_clear_len", 32'(cnt), 32'd7);

    bus_b.wr_en = 1'b1; bus_b.wr_addr = 3'd1; bus_b.wr_data = 32'h10;
    tick();
    bus_b.wr_addr = 3'd2; bus_b.wr_data = 32'h20;
    tick();
    bus_b.wr_en = 1'b0;
    bus_b.rd_en = 3'b111; bus_b.rd_addr = {3'd1, 3'd2, 3'd1};
    tick();
    check("b_p0_x1", bus_b.rd_data[31:0], 32'h10);
    check("b_p1_x2", bus_b.rd_data[63:32], 32'h20);
    check("b_p2_x1", bus_b.rd_data[95:64], 32'h10);

    // async reset mid-IDLE clears outputs immediately
    rst_n_b = 1'b0;
    #1;
    check("b_async_rd0", bus_b.rd_data[31:0], 32'd0);
    check("b_async_rd1", bus_b.rd_data[63:32], 32'd0);
    check("b_async_ready", 32'(bus_b.ready), 32'd0);
    tick();
    rst_n_b = 1'b1;
    count_ready_b(cnt);
    check("b_clear_len2", 32'(cnt), 32'd7);

    // reset at clear cycle 3 restarts the full sequence
    bus_b.clear = 1'b1;
    tick();
    bus_b.clear = 1'b0;
    tick();
    tick();
    rst_n_b = 1'b0;
    #1;
    check("b_midclr_ready", 32'(bus_b.ready), 32'd0);
    check("b_midclr_rd2", bus_b.rd_data[95:64], 32'd0);
    tick();
    rst_n_b = 1'b1;
    count_ready_b(cnt);
    check("b_clear_len3", 32'(cnt), 32'd7);
    tick();
    check("b_post_clr_x1", bus_b.rd_data[31:0], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
